// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// Round-robin on contention, one transaction in flight, IDLE -> REQ -> WAIT.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic              owner;  // 0 = IF, 1 = LS
  logic              last;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   be_q;
  logic              pick_ls;

  // On contention the side that did not own the last completed transaction wins.
  assign pick_ls = ls_req && (!if_req || !last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state)
        IDLE: if (if_req || ls_req) begin
          state <= REQ;
          if (pick_ls) begin
            owner   <= 1'b1;
            we_q    <= ls_we;
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            be_q    <= ls_be;
          end else begin
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            be_q    <= '1;
          end
        end
        REQ:  if (mem_gnt) state <= WAIT;
        WAIT: if (mem_rvalid) begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side fields come straight from the latched transaction, zeroed outside REQ.
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign mem_be    = mem_req ? be_q    : '0;

  assign if_gnt    = mem_req && mem_gnt && !owner;
  assign ls_gnt    = mem_req && mem_gnt &&  owner;
  assign if_rvalid = (state == WAIT) && mem_rvalid && !owner;
  assign ls_rvalid = (state == WAIT) && mem_rvalid &&  owner;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and load/store (LS).
- Sits between the fetch unit, LSU and the memory model inside core.
- One transaction in flight at a time.
- Round-robin arbitration on contention; a 3-state FSM sequences request, grant and response.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables are DW/8 bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held stable until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  fetch request accepted
if_rvalid  out  1  fetch read data valid
if_rdata  out  DW  fetch read data
ls_req  in  1  LSU request; held stable until ls_gnt
ls_we  in  1  1 = write
ls_addr  in  AW  LSU address
ls_wdata  in  DW  write data
ls_be  in  DW/8  byte enables
ls_gnt  out  1  LSU request accepted
ls_rvalid  out  1  LSU read data / write ack valid
ls_rdata  out  DW  LSU read data
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_be  out  DW/8  memory byte enables
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response; reads and writes both get exactly one
mem_rdata  in  DW  memory read data

Behaviour:
- States: IDLE, REQ, WAIT. Registers:
  - owner: 0 = IF, 1 = LS
  - last: owner of the last completed transaction
  - latched fields: we, addr, wdata, be
- Reset (async, rst=1):
  - state=IDLE, owner=0, last=1 (so IF wins the first contention).
  - All latched fields 0.
  - All outputs 0.
- IDLE:
  - Only if_req: owner=IF, latch addr, we=0, be=all ones, wdata=0 -> REQ.
  - Only ls_req: owner=LS, latch ls_* -> REQ.
  - Both: owner = ~last -> REQ.
  - Neither: stay.
- REQ:
  - mem_req=1; mem_we/addr/wdata/be driven from latched registers.
  - mem_gnt=1: gnt of owner asserted combinationally this cycle -> WAIT.
  - Otherwise stay; fields hold.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1: owner's rvalid=1 and rdata=mem_rdata, combinationally; last=owner -> IDLE.
- Latency: req seen in cycle N -> mem_req in cycle N+1 (registered). Minimum spacing between two grants is 3 cycles.
- Non-owner gnt and rvalid are always 0. if_rdata and ls_rdata are mem_rdata gated by their own rvalid, else 0.
- mem_rvalid in IDLE or REQ is ignored (no output effect, no state change).
- mem_gnt outside REQ is ignored.
- Requester dropping req before gnt: protocol violation. The latched transaction still completes; the response is delivered to that requester.
- Reset mid-transaction: any in-flight response is dropped; return to IDLE; a late mem_rvalid after reset is ignored.
- The same requester may re-request immediately after its rvalid. On contention, round robin guarantees the other requester the next grant.

Test Plan:
1. Reset, then if_req=1, if_addr=0x100, mem_gnt=1 in the next cycle, mem_rvalid one cycle later with mem_rdata=0xDEADBEEF -> mem_req high for exactly 1 cycle with mem_addr=0x100, mem_we=0, mem_be=0xF; if_gnt pulses; if_rvalid=1 with if_rdata=0xDEADBEEF; ls_* outputs remain 0.
2. LS write ls_addr=0x2000, ls_wdata=0x12345678, ls_be=0x3, mem_gnt held low 4 cycles -> mem_req stays high 5 cycles with fields stable; ls_gnt asserts only in the cycle mem_gnt=1; ls_rvalid asserts on the write ack.
3. if_req and ls_req both held continuously for 4 transactions from reset -> grant order IF, LS, IF, LS.
4. mem_rvalid pulsed while in IDLE and while in REQ -> no rvalid outputs, no state change; the subsequent real response is routed correctly.
5. rst=1 asserted during WAIT, then mem_rvalid=1 after rst=0 -> no rvalid outputs; all outputs 0 during reset; next request gets mem_req one cycle after its req.
6. IF transaction completes, and if_req is re-asserted together with ls_req in the following IDLE -> LS is granted first.
